// File: rtl/evm_multi_ctrl.sv
// Parametrised voting machine core: edge-detected ballots, saturating tallies, keyed result release.
// Optional wrong-key lockout is compiled in with `define KEY_LOCKOUT_EN.
module evm_multi_ctrl #(
    parameter int              N_CAND     = 4,
    parameter int              CNT_W      = 8,
    parameter int              KEY_W      = 4,
    parameter logic [KEY_W-1:0] PASSKEY   = 4'b1010,
    parameter int              ACK_CYCLES = 4,
    parameter int              MAX_TRIES  = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ballot_arm,
    input  logic                      poll_close,
    input  logic [N_CAND-1:0]         button,
    input  logic [KEY_W-1:0]          passkey,
    input  logic                      result_enable,
    output logic [N_CAND*CNT_W-1:0]   count_out,
    output logic [N_CAND-1:0]         led,
    output logic                      ballot_ready,
    output logic                      vote_err,
    output logic                      sat_flag,
    output logic                      results_valid,
    output logic [$clog2(N_CAND)-1:0] winner_idx,
    output logic                      tie,
    output logic                      key_locked
);
    localparam int IDX_W = $clog2(N_CAND);
    localparam int PC_W  = $clog2(N_CAND + 1);
    localparam int TMR_W = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACK, S_CLOSED} state_t;

    state_t            state, state_nx;
    logic [N_CAND-1:0] button_q, press;
    logic [CNT_W-1:0]  tally [N_CAND];
    logic [TMR_W-1:0]  timer;
    logic [PC_W-1:0]   n_press, n_max;
    logic [IDX_W-1:0]  vote_idx, best_idx;
    logic [CNT_W-1:0]  best;
    logic              vote_ok, vote_multi, release_c;

    assign press        = button & ~button_q;
    assign ballot_ready = (state == S_ARMED);

    always_comb begin
        n_press  = '0;
        vote_idx = '0;
        for (int i = 0; i < N_CAND; i++) begin
            if (press[i]) begin
                n_press  = n_press + 1'b1;
                vote_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // poll_close pre-empts everything, including a press landing on the same edge
    always_comb begin
        state_nx   = state;
        vote_ok    = 1'b0;
        vote_multi = 1'b0;
        if (poll_close) begin
            state_nx = S_CLOSED;
        end else begin
            case (state)
                S_IDLE:  if (ballot_arm) state_nx = S_ARMED;
                S_ARMED: begin
                    if (n_press == PC_W'(1)) begin
                        vote_ok  = 1'b1;
                        state_nx = S_ACK;
                    end else if (n_press > PC_W'(1)) begin
                        vote_multi = 1'b1;
                    end
                end
                S_ACK:    if (timer == '0) state_nx = S_IDLE;
                S_CLOSED: state_nx = S_CLOSED;
                default:  state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            button_q <= '0;
            led      <= '0;
            timer    <= '0;
            vote_err <= 1'b0;
            sat_flag <= 1'b0;
            for (int i = 0; i < N_CAND; i++) tally[i] <= '0;
        end else begin
            button_q <= button;
            vote_err <= vote_multi;
            if (vote_ok) begin
                if (tally[vote_idx] == CNT_MAX) sat_flag <= 1'b1;
                else                            tally[vote_idx] <= tally[vote_idx] + 1'b1;
                led   <= N_CAND'(1) << vote_idx;
                timer <= TMR_W'(ACK_CYCLES - 1);
            end else if (state_nx != S_ACK) begin
                led <= '0;
            end else if (timer != '0) begin
                timer <= timer - 1'b1;
            end
        end
    end

    // Leader search: strict '>' keeps the lowest index on equal tallies
    always_comb begin
        best     = '0;
        best_idx = '0;
        n_max    = '0;
        for (int i = 0; i < N_CAND; i++) begin
            if (tally[i] > best) begin
                best     = tally[i];
                best_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_CAND; i++) begin
            if (tally[i] == best) n_max = n_max + 1'b1;
        end
    end

    assign release_c = (state == S_CLOSED) && result_enable &&
                       (passkey == PASSKEY) && !key_locked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            results_valid <= 1'b0;
            winner_idx    <= '0;
            tie           <= 1'b0;
        end else begin
            results_valid <= release_c;
            winner_idx    <= release_c ? best_idx : '0;
            tie           <= release_c && (n_max >= PC_W'(2));
        end
    end

    always_comb begin
        count_out = '0;
        for (int i = 0; i < N_CAND; i++) begin
            count_out[i*CNT_W +: CNT_W] = results_valid ? tally[i] : '0;
        end
    end

`ifdef KEY_LOCKOUT_EN
    localparam int FC_W = $clog2(MAX_TRIES + 1);
    logic [FC_W-1:0] fail_cnt;
    logic            re_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt   <= '0;
            re_q       <= 1'b0;
            key_locked <= 1'b0;
        end else begin
            re_q <= result_enable;
            if (state == S_CLOSED && result_enable && !re_q &&
                passkey != PASSKEY && !key_locked) begin
                fail_cnt <= fail_cnt + 1'b1;
                if (fail_cnt == FC_W'(MAX_TRIES - 1)) key_locked <= 1'b1;
            end
        end
    end
`else
    // Always 0: MAX_TRIES only has meaning when the lockout is built in
    assign key_locked = (MAX_TRIES < 0);
`endif

endmodule

// File: tb/tb_evm_multi_ctrl.sv
// Self-checking bench for evm_multi_ctrl: directed scenarios plus a random ballot run
// against a tally-array reference; a CNT_W=2 twin shares the stimulus for saturation.
module tb_evm_multi_ctrl;
    localparam logic [3:0] KEY = 4'b1010;
    localparam int ACK = 4;

    logic       clk, rst_n, ballot_arm, poll_close, result_enable;
    logic [3:0] button, passkey;
    logic [31:0] count_out;
    logic [7:0]  count2;
    logic [3:0]  led, led2;
    logic [1:0]  winner_idx, winner2;
    logic ballot_ready, vote_err, sat_flag, results_valid, tie, key_locked;
    logic ready2, err2, sat2, rv2, tie2, lock2;

    int n_assert = 0;
    int n_fail   = 0;
    int mdl[4];
    int mdl2[4];
    bit exp_sat, exp_sat2;

    evm_multi_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ballot_arm(ballot_arm), .poll_close(poll_close),
        .button(button), .passkey(passkey), .result_enable(result_enable),
        .count_out(count_out), .led(led), .ballot_ready(ballot_ready), .vote_err(vote_err),
        .sat_flag(sat_flag), .results_valid(results_valid), .winner_idx(winner_idx),
        .tie(tie), .key_locked(key_locked)
    );

    evm_multi_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ballot_arm(ballot_arm), .poll_close(poll_close),
        .button(button), .passkey(passkey), .result_enable(result_enable),
        .count_out(count2), .led(led2), .ballot_ready(ready2), .vote_err(err2),
        .sat_flag(sat2), .results_valid(rv2), .winner_idx(winner2),
        .tie(tie2), .key_locked(lock2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ballot_arm = 1'b0; poll_close = 1'b0; button = '0;
        passkey = '0; result_enable = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin mdl[i] = 0; mdl2[i] = 0; end
        exp_sat = 1'b0; exp_sat2 = 1'b0;
    endtask

    // Reference: each accepted vote adds one, clamped at the tally ceiling
    task automatic model_vote(input int c);
        if (mdl[c] == 255) exp_sat = 1'b1; else mdl[c]++;
        if (mdl2[c] == 3) exp_sat2 = 1'b1; else mdl2[c]++;
    endtask

    function automatic void ref_winner(input int t[4], output int w, output bit tied);
        int mx = 0;
        int n  = 0;
        w = 0;
        foreach (t[i]) if (t[i] > mx) begin mx = t[i]; w = i; end
        foreach (t[i]) if (t[i] == mx) n++;
        tied = (n >= 2);
    endfunction

    task automatic vote(input int c, input logic [3:0] bad);
        ballot_arm = 1'b1; tick(); ballot_arm = 1'b0;
        if (bad != '0) begin
            button = bad; tick();
            chk("vote_err_multi", vote_err, 1'b1);
            chk("ready_after_err", ballot_ready, 1'b1);
            button = '0; tick();
        end
        button = 4'b0001 << c; tick();
        chk("vote_led", led, 4'b0001 << c);
        chk("vote_led2", led2, 4'b0001 << c);
        model_vote(c);
        button = '0;
        repeat (ACK) tick();
    endtask

    task automatic check_results();
        int  w, w2;
        bit  t, t2;
        poll_close = 1'b1; tick(); poll_close = 1'b0;
        chk("closed_ready", ballot_ready, 1'b0);
        chk("closed_led", led, 4'b0);
        passkey = KEY; result_enable = 1'b1; tick();
        chk("rv", results_valid, 1'b1);
        chk("rv2", rv2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("count", count_out[i*8 +: 8], mdl[i][7:0]);
            chk("count2", count2[i*2 +: 2], mdl2[i][1:0]);
        end
        ref_winner(mdl, w, t);
        ref_winner(mdl2, w2, t2);
        chk("winner", winner_idx, w[1:0]);
        chk("tie", tie, t);
        chk("winner2", winner2, w2[1:0]);
        chk("tie2", tie2, t2);
        chk("sat", sat_flag, exp_sat);
        chk("sat2", sat2, exp_sat2);
        result_enable = 1'b0; tick();
        chk("rv_deassert", results_valid, 1'b0);
        chk("count_hidden", count_out, 32'h0);
    endtask

    initial begin
        int led_hi;
        logic [3:0] m;

        // Reset state
        do_reset();
        chk("rst_led", led, 4'b0);
        chk("rst_ready", ballot_ready, 1'b0);
        chk("rst_err", vote_err, 1'b0);
        chk("rst_rv", results_valid, 1'b0);
        chk("rst_count", count_out, 32'h0);
        chk("rst_lock", key_locked, 1'b0);

        // 1: single-cycle press then a held press; LED widths and edge-only counting
        ballot_arm = 1'b1; tick(); ballot_arm = 1'b0;
        chk("armed_ready", ballot_ready, 1'b1);
        button = 4'b0001; tick(); button = '0;
        model_vote(0);
        led_hi = 0;
        repeat (7) begin if (led == 4'b0001) led_hi++; tick(); end
        chk("led0_cycles", led_hi, ACK);
        ballot_arm = 1'b1; tick(); ballot_arm = 1'b0;
        button = 4'b0010;
        led_hi = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 6) ballot_arm = 1'b1;
            if (k == 7) ballot_arm = 1'b0;
            if (k == 11) button = '0;
            tick();
            if (led == 4'b0010) led_hi++;
        end
        model_vote(1);
        chk("led1_cycles", led_hi, ACK);
        chk("held_no_revote", ballot_ready, 1'b1);
        check_results();

        // 2: press while idle is ignored
        do_reset();
        button = 4'b0100; tick();
        chk("idle_led", led, 4'b0);
        chk("idle_err", vote_err, 1'b0);
        button = '0; tick();
        check_results();

        // 3: two buttons at once flag an error; a later single press still counts
        do_reset();
        ballot_arm = 1'b1; tick(); ballot_arm = 1'b0;
        button = 4'b1010; tick();
        chk("multi_err", vote_err, 1'b1);
        chk("multi_ready", ballot_ready, 1'b1);
        chk("multi_led", led, 4'b0);
        button = '0; tick();
        chk("err_pulse_end", vote_err, 1'b0);
        chk("still_ready", ballot_ready, 1'b1);
        button = 4'b1000; tick(); button = '0;
        model_vote(3);
        chk("single_led", led, 4'b1000);
        repeat (ACK) tick();
        check_results();

        // 4: saturation on the 2-bit twin; 4th vote still acknowledged
        do_reset();
        for (int k = 0; k < 4; k++) vote(0, 4'b0);
        chk("sat2_flag", sat2, 1'b1);
        chk("sat_flag_8b", sat_flag, 1'b0);
        check_results();

        // 5: wrong key hides results, then release; close discards a same-cycle press
        do_reset();
        repeat (2) vote(0, 4'b0);
        repeat (5) vote(1, 4'b0);
        vote(2, 4'b0);
        vote(3, 4'b0);
        ballot_arm = 1'b1; tick(); ballot_arm = 1'b0;
        button = 4'b0001; poll_close = 1'b1; tick();
        button = '0; poll_close = 1'b0;
        chk("close_press_led", led, 4'b0);
        passkey = 4'b0000; result_enable = 1'b1; tick();
        chk("wrong_key_rv", results_valid, 1'b0);
        chk("wrong_key_count", count_out, 32'h0);
        result_enable = 1'b0; tick();
        check_results();
        do_reset();
        repeat (3) vote(0, 4'b0);
        repeat (3) vote(1, 4'b0);
        check_results();

        // 6: repeated wrong-key attempts, then async reset clears everything
        do_reset();
        vote(2, 4'b0);
        poll_close = 1'b1; tick(); poll_close = 1'b0;
        passkey = 4'b0000;
        repeat (3) begin result_enable = 1'b1; tick(); result_enable = 1'b0; tick(); end
        passkey = KEY; result_enable = 1'b1; tick(); tick();
`ifdef KEY_LOCKOUT_EN
        chk("locked", key_locked, 1'b1);
        chk("locked_rv", results_valid, 1'b0);
`else
        chk("no_lock", key_locked, 1'b0);
        chk("unlimited_rv", results_valid, 1'b1);
        chk("unlimited_count", count_out[23:16], 8'd1);
`endif
        rst_n = 1'b0; #1;
        chk("async_lock", key_locked, 1'b0);
        chk("async_rv", results_valid, 1'b0);
        chk("async_count", count_out, 32'h0);
        rst_n = 1'b1; result_enable = 1'b0;

        // Random ballots, some preceded by an invalid multi-press
        do_reset();
        for (int k = 0; k < 40; k++) begin
            m = '0;
            if ($urandom_range(0, 3) == 0) begin
                while ($countones(m) < 2) m = 4'($urandom_range(0, 15));
            end
            vote($urandom_range(0, 3), m);
        end
        check_results();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
